lsu_dmem_master: RTL and testbench
==================================

Name: lsu_dmem_master

Overview:
- Initiator side of the CPU data-memory request/response interface; sits between the memory reservation-station dispatch and the word-addressed dmem port.
- Accepts one RV32 load/store op at a time and issues word-aligned requests. Sub-word stores use read-modify-write because the dmem port has no byte enables.
- Loads are extracted and sign/zero-extended, then the result is returned with its ROB tag on a CDB-style valid/ready port.

Parameters:
- TAG_W, 6, width of ROB tag carried with each op.
- RESP_TIMEOUT, 255, cycles to wait for dmem_resp_valid before flagging a bus error (8-bit counter).

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- op_valid  in  1  op offered by dispatch
- op_ready  out  1  block idle and able to accept
- op_funct3  in  3  RV32 LB=000 LH=001 LW=010 LBU=100 LHU=101; stores SB=000 SH=001 SW=010
- op_is_store  in  1  1=store, 0=load
- op_addr  in  32  byte address (already base+imm)
- op_wdata  in  32  store data (rs2)
- op_tag  in  TAG_W  ROB tag
- flush  in  1  pipeline flush; abandon current op
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  memory accepts request this cycle
- dmem_req_we  out  1  1=write
- dmem_req_addr  out  32  word-aligned address ({op_addr[31:2],2'b00})
- dmem_req_data  out  32  write word
- dmem_resp_valid  in  1  read data valid (one-cycle pulse)
- dmem_resp_data  in  32  read word
- res_valid  out  1  completion valid
- res_ready  in  1  CDB arbiter accepts
- res_tag  out  TAG_W  ROB tag of completing op
- res_data  out  32  load result; 0 for stores
- res_exc  out  2  0=ok, 1=misaligned, 2=bus timeout

Behaviour:
- Reset: all outputs 0 except op_ready=1; FSM=IDLE; counters 0.
- States: IDLE, REQ, WAIT, RMW_WR, RESULT, DRAIN.
- IDLE: on op_valid & op_ready, latch the op; op_ready drops the next cycle.
  - Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): go to RESULT with res_exc=1 and no memory request.
  - Otherwise go to REQ.
- REQ: dmem_req_valid=1 with addr/we/data held stable until dmem_req_ready. Request type:
  - SW: write op_wdata.
  - Load or SB/SH: read.
  - On accept: SW goes to RESULT; reads go to WAIT.
- WAIT: timeout counter increments each cycle.
  - On dmem_resp_valid, a load extracts lane addr[1:0], sign- or zero-extends per funct3, then goes to RESULT.
  - SB/SH merge the byte/half into the read word at lane addr[1:0], then go to RMW_WR.
  - Counter reaching RESP_TIMEOUT: RESULT with res_exc=2.
  - Response arrival earliest 1 cycle after request accept; any latency ≥1 supported.
- RMW_WR: write the merged word (same address); hold until dmem_req_ready, then RESULT.
- RESULT: res_valid=1 with tag/data/exc stable until res_ready, then IDLE. op_ready=1 only in IDLE, so back-to-back ops take ≥1 bubble.
- flush:
  - In IDLE/REQ/RESULT: go to IDLE next cycle, drop res_valid, issue no further request.
  - In REQ, a request accepted in the same cycle as flush still counts as issued. If it was a read, go to DRAIN.
  - In WAIT: go to DRAIN. Wait for the outstanding dmem_resp_valid (or timeout), discard it, go to IDLE. No RMW write is issued.
  - In RMW_WR: finish the write (memory consistency), then IDLE with no result.
  - flush and op_valid in the same IDLE cycle: op not accepted.
- dmem_resp_valid in IDLE/REQ/RESULT is ignored (spurious).
- reset mid-operation: immediate return to reset values; outstanding transaction forgotten.

Test Plan:
- LW 0x100 where mem[0x40]=0xDEADBEEF, ready=1, latency 1: one read req at addr 0x100, res_data=0xDEADBEEF with tag, res_exc=0.
- LB 0x103 and LBU 0x103, same word: res_data=0xFFFFFFDE then 0x000000DE; LH 0x102 gives 0xFFFFDEAD.
- SB 0x101, wdata 0x55, word 0x11223344: read, then write 0x11225544 to 0x100; res_data=0. SW issues a single write.
- dmem_req_ready low 3 cycles: addr/we/data stable throughout, exactly one accept. res_ready low 2 cycles: res_* held.
- LW 0x102 gives res_exc=1 with no dmem request. A load with no response gives res_exc=2 exactly RESP_TIMEOUT cycles after accept.
- flush during WAIT, response 2 cycles later: no res_valid; op_ready returns only after the response is absorbed. flush during RMW_WR: the write still completes, no result.

Source files
------------

// File: rtl/lsu_dmem_master_if.sv
// Load/store unit bundle: dispatch op, word-addressed dmem port,
// and completion port toward the CDB arbiter.
interface lsu_dmem_master_if #(
   parameter int TAG_W = 6
);
   logic             op_valid;
   logic             op_ready;
   logic [2:0]       op_funct3;
   logic             op_is_store;
   logic [31:0]      op_addr;
   logic [31:0]      op_wdata;
   logic [TAG_W-1:0] op_tag;
   logic             flush;
   logic             dmem_req_valid;
   logic             dmem_req_ready;
   logic             dmem_req_we;
   logic [31:0]      dmem_req_addr;
   logic [31:0]      dmem_req_data;
   logic             dmem_resp_valid;
   logic [31:0]      dmem_resp_data;
   logic             res_valid;
   logic             res_ready;
   logic [TAG_W-1:0] res_tag;
   logic [31:0]      res_data;
   logic [1:0]       res_exc;

   modport master (
      input  op_valid, op_funct3, op_is_store, op_addr,
      input  op_wdata, op_tag, flush,
      input  dmem_req_ready, dmem_resp_valid, dmem_resp_data,
      input  res_ready,
      output op_ready, dmem_req_valid, dmem_req_we,
      output dmem_req_addr, dmem_req_data,
      output res_valid, res_tag, res_data, res_exc
   );

   modport slave (
      output op_valid, op_funct3, op_is_store, op_addr,
      output op_wdata, op_tag, flush,
      output dmem_req_ready, dmem_resp_valid, dmem_resp_data,
      output res_ready,
      input  op_ready, dmem_req_valid, dmem_req_we,
      input  dmem_req_addr, dmem_req_data,
      input  res_valid, res_tag, res_data, res_exc
   );
endinterface

// File: rtl/lsu_dmem_master.sv
// Single-op RV32 load/store master for a word-only dmem port;
// sub-word stores are done as read-modify-write.
module lsu_dmem_master #(
   parameter int TAG_W        = 6,
   parameter int RESP_TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   lsu_dmem_master_if.master    bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_WAIT, S_RMW_WR, S_RESULT, S_DRAIN
   } state_t;

   localparam logic [7:0] TMO_LAST = 8'(RESP_TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [2:0]       funct3_q, funct3_d;
   logic             store_q, store_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [31:0]      rdata_q, rdata_d;
   logic [1:0]       exc_q, exc_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             flushed_q, flushed_d;

   logic        sz_b, sz_h, is_sw, mis, tmo;
   logic [4:0]  sh;
   logic [31:0] lane, ld_ext, mask, merged;

   assign sz_b  = funct3_q[1:0] == 2'b00;
   assign sz_h  = funct3_q[1:0] == 2'b01;
   assign is_sw = store_q & funct3_q[1];
   assign sh    = {addr_q[1:0], 3'b000};
   assign tmo   = cnt_q == TMO_LAST;
   assign lane  = bus.dmem_resp_data >> sh;

   // Alignment is judged on the incoming op, before it is latched.
   assign mis = (bus.op_funct3[1:0] == 2'b01 & bus.op_addr[0]) |
                (bus.op_funct3[1] & (bus.op_addr[1:0] != 2'b00));

   always_comb begin
      ld_ext = lane;
      mask   = 32'hFFFF_FFFF;
      unique case (1'b1)
         sz_b: begin
            ld_ext = {{24{~funct3_q[2] & lane[7]}}, lane[7:0]};
            mask   = 32'h0000_00FF << sh;
         end
         sz_h: begin
            ld_ext = {{16{~funct3_q[2] & lane[15]}}, lane[15:0]};
            mask   = 32'h0000_FFFF << sh;
         end
         default: ;
      endcase
      merged = (bus.dmem_resp_data & ~mask) | ((wdata_q << sh) & mask);
   end

   always_comb begin
      state_d   = state_q;
      funct3_d  = funct3_q;
      store_d   = store_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      tag_d     = tag_q;
      rdata_d   = rdata_q;
      exc_d     = exc_q;
      cnt_d     = cnt_q;
      flushed_d = flushed_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.op_valid && !bus.flush) begin
               funct3_d  = bus.op_funct3;
               store_d   = bus.op_is_store;
               addr_d    = bus.op_addr;
               wdata_d   = bus.op_wdata;
               tag_d     = bus.op_tag;
               rdata_d   = '0;
               cnt_d     = '0;
               flushed_d = 1'b0;
               exc_d     = mis ? 2'd1 : 2'd0;
               state_d   = mis ? S_RESULT : S_REQ;
            end
         end
         S_REQ: begin
            if (bus.flush)
               state_d = (bus.dmem_req_ready && !is_sw) ? S_DRAIN : S_IDLE;
            else if (bus.dmem_req_ready)
               state_d = is_sw ? S_RESULT : S_WAIT;
         end
         S_WAIT: begin
            if (bus.dmem_resp_valid) begin
               if (bus.flush) begin
                  state_d = S_IDLE;
               end else if (store_q) begin
                  wdata_d = merged;
                  state_d = S_RMW_WR;
               end else begin
                  rdata_d = ld_ext;
                  state_d = S_RESULT;
               end
            end else if (tmo) begin
               exc_d   = 2'd2;
               state_d = bus.flush ? S_IDLE : S_RESULT;
            end else begin
               cnt_d = cnt_q + 8'd1;
               if (bus.flush) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (bus.dmem_resp_valid || tmo) state_d = S_IDLE;
            else cnt_d = cnt_q + 8'd1;
         end
         S_RMW_WR: begin
            flushed_d = flushed_q | bus.flush;
            if (bus.dmem_req_ready)
               state_d = flushed_d ? S_IDLE : S_RESULT;
         end
         S_RESULT: begin
            if (bus.flush || bus.res_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         funct3_q  <= '0;
         store_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         tag_q     <= '0;
         rdata_q   <= '0;
         exc_q     <= '0;
         cnt_q     <= '0;
         flushed_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         funct3_q  <= funct3_d;
         store_q   <= store_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         tag_q     <= tag_d;
         rdata_q   <= rdata_d;
         exc_q     <= exc_d;
         cnt_q     <= cnt_d;
         flushed_q <= flushed_d;
      end
   end

   logic req_v, req_we, res_v;
   assign req_v  = (state_q == S_REQ) | (state_q == S_RMW_WR);
   assign req_we = (state_q == S_REQ & is_sw) | (state_q == S_RMW_WR);
   assign res_v  = state_q == S_RESULT;

   assign bus.op_ready       = state_q == S_IDLE;
   assign bus.dmem_req_valid = req_v;
   assign bus.dmem_req_we    = req_we;
   assign bus.dmem_req_addr  = req_v ? {addr_q[31:2], 2'b00} : '0;
   assign bus.dmem_req_data  = req_we ? wdata_q : '0;
   assign bus.res_valid      = res_v;
   assign bus.res_tag        = res_v ? tag_q : '0;
   assign bus.res_data       = res_v ? rdata_q : '0;
   assign bus.res_exc        = res_v ? exc_q : '0;
endmodule

// File: tb/tb_lsu_dmem_master.sv
// Directed bench for lsu_dmem_master with a small word memory
// responder of programmable latency.
module tb_lsu_dmem_master;
   localparam int TW  = 6;
   localparam int TMO = 255;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   lsu_dmem_master_if #(.TAG_W(TW)) bus();
   lsu_dmem_master #(.TAG_W(TW), .RESP_TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   int total = 0;
   int bad = 0;
   logic [31:0] mem [0:255];
   int n_rd, n_wr, cyc, acc_cyc, lat, resp_lat, res_seen;
   bit pend, resp_en;
   logic [31:0] pend_data, last_ra, last_wa;

   always @(posedge clk) begin
      cyc++;
      if (bus.res_valid === 1'b1) res_seen++;
      if (reset) begin
         pend = 1'b0;
      end else if (bus.dmem_req_valid && bus.dmem_req_ready) begin
         acc_cyc = cyc;
         if (bus.dmem_req_we) begin
            mem[bus.dmem_req_addr[9:2]] = bus.dmem_req_data;
            n_wr++;
            last_wa = bus.dmem_req_addr;
         end else begin
            n_rd++;
            last_ra = bus.dmem_req_addr;
            if (resp_en) begin
               pend = 1'b1;
               lat = resp_lat;
               pend_data = mem[bus.dmem_req_addr[9:2]];
            end
         end
      end
   end

   always @(negedge clk) begin
      bus.dmem_resp_valid = 1'b0;
      bus.dmem_resp_data  = '0;
      if (pend) begin
         if (lat <= 1) begin
            bus.dmem_resp_valid = 1'b1;
            bus.dmem_resp_data  = pend_data;
            pend = 1'b0;
         end else begin
            lat--;
         end
      end
   end

   task automatic issue(input bit st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [TW-1:0] tg);
      bus.op_valid = 1'b1;
      bus.op_is_store = st;
      bus.op_funct3 = f3;
      bus.op_addr = a;
      bus.op_wdata = wd;
      bus.op_tag = tg;
      @(negedge clk);
      bus.op_valid = 1'b0;
   endtask

   task automatic wait_res(input int lim);
      int n = 0;
      while (bus.res_valid !== 1'b1 && n < lim) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic clr;
      n_rd = 0; n_wr = 0; res_seen = 0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      bus.op_valid = 0; bus.op_funct3 = 0; bus.op_is_store = 0;
      bus.op_addr = 0; bus.op_wdata = 0; bus.op_tag = 0;
      bus.flush = 0; bus.dmem_req_ready = 1; bus.res_ready = 1;
      resp_en = 1; resp_lat = 1; pend = 0; cyc = 0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      repeat (3) @(negedge clk);
      total++; if (bus.op_ready !== 1'b1) begin bad++; $display("FAIL rst_op_ready got=%0h exp=1", bus.op_ready); end
      total++; if (bus.dmem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%0h exp=0", bus.dmem_req_valid); end
      total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid got=%0h exp=0", bus.res_valid); end
      total++; if ({bus.res_data, bus.res_tag, bus.res_exc} !== '0) begin bad++; $display("FAIL rst_res_fields got=%0h exp=0", {bus.res_data, bus.res_tag, bus.res_exc}); end
      total++; if ({bus.dmem_req_addr, bus.dmem_req_data, bus.dmem_req_we} !== '0) begin bad++; $display("FAIL rst_req_fields got=%0h exp=0", {bus.dmem_req_addr, bus.dmem_req_data}); end
      reset = 1'b0;
      @(negedge clk);
      clr();
   endtask

   task automatic test_lw;
      mem[64] = 32'hDEADBEEF;
      clr();
      issue(0, 3'b010, 32'h100, 32'h0, 6'h05);
      wait_res(20);
      total++; if (bus.res_valid !== 1'b1) begin bad++; $display("FAIL lw_valid got=%0h exp=1", bus.res_valid); end
      total++; if (bus.res_data !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data got=%h exp=deadbeef", bus.res_data); end
      total++; if (bus.res_tag !== 6'h05) begin bad++; $display("FAIL lw_tag got=%h exp=05", bus.res_tag); end
      total++; if (bus.res_exc !== 2'd0) begin bad++; $display("FAIL lw_exc got=%0d exp=0", bus.res_exc); end
      total++; if (n_rd !== 1 || n_wr !== 0 || last_ra !== 32'h100) begin bad++; $display("FAIL lw_bus got rd=%0d wr=%0d addr=%h exp rd=1 wr=0 addr=100", n_rd, n_wr, last_ra); end
      @(negedge clk);
      total++; if (bus.op_ready !== 1'b1 || bus.res_valid !== 1'b0) begin bad++; $display("FAIL lw_idle got rdy=%0h rv=%0h exp 1 0", bus.op_ready, bus.res_valid); end
   endtask

   task automatic test_sub_loads;
      logic [2:0]  f3 [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
      logic [31:0] ad [4] = '{32'h103, 32'h103, 32'h102, 32'h100};
      logic [31:0] ex [4] = '{32'hFFFFFFDE, 32'h000000DE,
                              32'hFFFFDEAD, 32'h0000BEEF};
      for (int i = 0; i < 4; i++) begin
         issue(0, f3[i], ad[i], 32'h0, 6'(i + 8));
         wait_res(20);
         total++; if (bus.res_data !== ex[i] || bus.res_valid !== 1'b1) begin bad++; $display("FAIL subload%0d got=%h exp=%h", i, bus.res_data, ex[i]); end
         @(negedge clk);
      end
   endtask

   task automatic test_stores;
      mem[64] = 32'h11223344;
      clr();
      issue(1, 3'b000, 32'h101, 32'hAAAAAA55, 6'h07);
      wait_res(20);
      total++; if (bus.res_data !== 32'h0 || bus.res_exc !== 2'd0 || bus.res_tag !== 6'h07) begin bad++; $display("FAIL sb_res got d=%h e=%0d t=%h exp 0 0 07", bus.res_data, bus.res_exc, bus.res_tag); end
      total++; if (n_rd !== 1 || n_wr !== 1 || last_wa !== 32'h100) begin bad++; $display("FAIL sb_bus got rd=%0d wr=%0d wa=%h exp 1 1 100", n_rd, n_wr, last_wa); end
      total++; if (mem[64] !== 32'h11225544) begin bad++; $display("FAIL sb_word got=%h exp=11225544", mem[64]); end
      @(negedge clk);
      issue(1, 3'b001, 32'h102, 32'h00009977, 6'h08);
      wait_res(20);
      @(negedge clk);
      total++; if (mem[64] !== 32'h99775544) begin bad++; $display("FAIL sh_word got=%h exp=99775544", mem[64]); end
      clr();
      issue(1, 3'b010, 32'h104, 32'hCAFEF00D, 6'h09);
      wait_res(20);
      total++; if (n_rd !== 0 || n_wr !== 1 || last_wa !== 32'h104) begin bad++; $display("FAIL sw_bus got rd=%0d wr=%0d wa=%h exp 0 1 104", n_rd, n_wr, last_wa); end
      total++; if (mem[65] !== 32'hCAFEF00D) begin bad++; $display("FAIL sw_word got=%h exp=cafef00d", mem[65]); end
      @(negedge clk);
   endtask

   task automatic test_stall;
      clr();
      bus.dmem_req_ready = 1'b0;
      issue(1, 3'b010, 32'h108, 32'h12345678, 6'h03);
      for (int i = 0; i < 3; i++) begin
         total++; if (bus.dmem_req_valid !== 1'b1 || bus.dmem_req_we !== 1'b1 || bus.dmem_req_addr !== 32'h108 || bus.dmem_req_data !== 32'h12345678) begin bad++; $display("FAIL stall_req%0d got v=%0h we=%0h a=%h d=%h", i, bus.dmem_req_valid, bus.dmem_req_we, bus.dmem_req_addr, bus.dmem_req_data); end
         @(negedge clk);
      end
      bus.dmem_req_ready = 1'b1;
      bus.res_ready = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         total++; if (bus.res_valid !== 1'b1 || bus.res_tag !== 6'h03 || bus.res_exc !== 2'd0) begin bad++; $display("FAIL res_hold%0d got v=%0h t=%h e=%0d exp 1 03 0", i, bus.res_valid, bus.res_tag, bus.res_exc); end
         @(negedge clk);
      end
      bus.res_ready = 1'b1;
      @(negedge clk);
      total++; if (bus.res_valid !== 1'b0 || bus.op_ready !== 1'b1) begin bad++; $display("FAIL stall_done got rv=%0h rdy=%0h exp 0 1", bus.res_valid, bus.op_ready); end
      total++; if (n_wr !== 1 || mem[66] !== 32'h12345678) begin bad++; $display("FAIL stall_accepts got wr=%0d word=%h exp 1 12345678", n_wr, mem[66]); end
   endtask

   task automatic test_misaligned;
      clr();
      issue(0, 3'b010, 32'h102, 32'h0, 6'h11);
      wait_res(20);
      total++; if (bus.res_exc !== 2'd1 || bus.res_tag !== 6'h11) begin bad++; $display("FAIL mis_lw got e=%0d t=%h exp 1 11", bus.res_exc, bus.res_tag); end
      @(negedge clk);
      issue(1, 3'b001, 32'h101, 32'h0, 6'h12);
      wait_res(20);
      total++; if (bus.res_exc !== 2'd1) begin bad++; $display("FAIL mis_sh got e=%0d exp 1", bus.res_exc); end
      @(negedge clk);
      total++; if (n_rd !== 0 || n_wr !== 0) begin bad++; $display("FAIL mis_nobus got rd=%0d wr=%0d exp 0 0", n_rd, n_wr); end
   endtask

   task automatic test_timeout;
      clr();
      resp_en = 1'b0;
      issue(0, 3'b010, 32'h100, 32'h0, 6'h2A);
      wait_res(400);
      total++; if (bus.res_valid !== 1'b1 || bus.res_exc !== 2'd2) begin bad++; $display("FAIL tmo_exc got v=%0h e=%0d exp 1 2", bus.res_valid, bus.res_exc); end
      total++; if (cyc - acc_cyc !== TMO) begin bad++; $display("FAIL tmo_cycles got=%0d exp=%0d", cyc - acc_cyc, TMO); end
      @(negedge clk);
      resp_en = 1'b1;
   endtask

   task automatic test_flush_wait;
      clr();
      resp_lat = 3;
      issue(0, 3'b010, 32'h100, 32'h0, 6'h01);
      @(negedge clk);
      total++; if (n_rd !== 1) begin bad++; $display("FAIL fw_read got=%0d exp=1", n_rd); end
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      total++; if (bus.op_ready !== 1'b0) begin bad++; $display("FAIL fw_drain1 got rdy=%0h exp 0", bus.op_ready); end
      @(negedge clk);
      total++; if (bus.op_ready !== 1'b0) begin bad++; $display("FAIL fw_drain2 got rdy=%0h exp 0", bus.op_ready); end
      @(negedge clk);
      total++; if (bus.op_ready !== 1'b1) begin bad++; $display("FAIL fw_idle got rdy=%0h exp 1", bus.op_ready); end
      repeat (3) @(negedge clk);
      total++; if (res_seen !== 0 || n_wr !== 0) begin bad++; $display("FAIL fw_nores got res=%0d wr=%0d exp 0 0", res_seen, n_wr); end
      resp_lat = 1;
   endtask

   task automatic test_flush_rmw;
      mem[64] = 32'h11223344;
      clr();
      issue(1, 3'b000, 32'h102, 32'h00000066, 6'h04);
      @(negedge clk);
      bus.dmem_req_ready = 1'b0;
      @(negedge clk);
      total++; if (bus.dmem_req_valid !== 1'b1 || bus.dmem_req_we !== 1'b1 || bus.dmem_req_data !== 32'h11663344) begin bad++; $display("FAIL fr_wr got v=%0h we=%0h d=%h exp 1 1 11663344", bus.dmem_req_valid, bus.dmem_req_we, bus.dmem_req_data); end
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      bus.dmem_req_ready = 1'b1;
      @(negedge clk);
      total++; if (n_wr !== 1 || mem[64] !== 32'h11663344) begin bad++; $display("FAIL fr_write got wr=%0d word=%h exp 1 11663344", n_wr, mem[64]); end
      total++; if (bus.op_ready !== 1'b1) begin bad++; $display("FAIL fr_idle got rdy=%0h exp 1", bus.op_ready); end
      repeat (3) @(negedge clk);
      total++; if (res_seen !== 0) begin bad++; $display("FAIL fr_nores got=%0d exp=0", res_seen); end
   endtask

   task automatic test_back_to_back;
      clr();
      bus.flush = 1'b1;
      issue(0, 3'b010, 32'h100, 32'h0, 6'h15);
      bus.flush = 1'b0;
      total++; if (bus.op_ready !== 1'b1 || bus.dmem_req_valid !== 1'b0) begin bad++; $display("FAIL flush_idle got rdy=%0h rv=%0h exp 1 0", bus.op_ready, bus.dmem_req_valid); end
      bus.dmem_req_ready = 1'b0;
      issue(0, 3'b010, 32'h100, 32'h0, 6'h16);
      total++; if (bus.op_ready !== 1'b0 || bus.dmem_req_valid !== 1'b1) begin bad++; $display("FAIL busy got rdy=%0h rv=%0h exp 0 1", bus.op_ready, bus.dmem_req_valid); end
      reset = 1'b1;
      #1;
      total++; if (bus.op_ready !== 1'b1 || bus.dmem_req_valid !== 1'b0) begin bad++; $display("FAIL mid_reset got rdy=%0h rv=%0h exp 1 0", bus.op_ready, bus.dmem_req_valid); end
      @(negedge clk);
      reset = 1'b0;
      bus.dmem_req_ready = 1'b1;
      repeat (2) @(negedge clk);
      total++; if (n_rd !== 0 || res_seen !== 0) begin bad++; $display("FAIL after_reset got rd=%0d res=%0d exp 0 0", n_rd, res_seen); end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_sub_loads();
      test_stores();
      test_stall();
      test_misaligned();
      test_timeout();
      test_flush_wait();
      test_flush_rmw();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
